stream_source: RTL and testbench
================================

# stream_source

Synthesizable stream producer: the transmitting end of the integer stream protocol that lowered stream circuits consume. On one control token it emits an arithmetic sequence of `count` 64-bit elements on a data/EOS stream, then a single EOS element, then a completion token. It feeds stream inputs of generated `top` circuits in integration tests and on-chip, and pairs with the existing output-side driver logic.

## Interface
- `DATA_WIDTH`, 64: element payload width (`out0_data_field0`).
- `COUNT_WIDTH`, 16: width of the element-count config.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; asserted (0) clears all state immediately.
- `inCtrl_valid` in 1: start token offered.
- `inCtrl_ready` out 1: start token accepted when both high.
- `cfg_start` in DATA_WIDTH: first element value; sampled on the start handshake.
- `cfg_step` in DATA_WIDTH: increment between elements; sampled on the start handshake.
- `cfg_count` in COUNT_WIDTH: number of data elements; sampled on the start handshake.
- `out0_valid` out 1: element offered.
- `out0_ready` in 1: consumer accepts element.
- `out0_data_field0` out DATA_WIDTH: element value; 0 on the EOS element.
- `out0_data_field1` out 1: 1 = EOS element, 0 = data element.
- `outCtrl_valid` out 1: completion token offered.
- `outCtrl_ready` in 1: completion token accepted.

## Operation
- States: IDLE, EMIT, EOS, DONE.
- IDLE: `inCtrl_ready`=1. On `inCtrl_valid`, capture `cfg_*` and go to EMIT, or to EOS if `cfg_count`=0. Load the output register with `cfg_start` and field1=0.
- EMIT: `out0_valid`=1, field1=0. On `out0_ready`, decrement remaining. If remaining was 1, go to EOS. Otherwise load value+step.
- Value arithmetic is modulo 2^DATA_WIDTH; wrap-around is silent and unsigned.
- EOS: `out0_valid`=1, field1=1, field0=0. On `out0_ready`, go to DONE.
- DONE: `outCtrl_valid`=1. On `outCtrl_ready`, go to IDLE.
- Valid/data hold rule: once `out0_valid` is high, it and both data fields stay stable until the handshake. The same rule applies to `outCtrl_valid`.
- `inCtrl_ready` is 0 outside IDLE. Start tokens offered mid-sequence are not consumed, and config changes mid-sequence are ignored.
- Reset asserted in any state: return to IDLE at once. Any in-flight sequence is abandoned; no EOS and no completion token are emitted.

## Timing
- Reset values: `inCtrl_ready`=1 (IDLE), `out0_valid`=0, `out0_data_field0`=0, `out0_data_field1`=0, `outCtrl_valid`=0.
- All outputs come straight from registers or from the state decode; there is no combinational path from an input to an output.
- Start handshake at cycle t leads to the first element valid at t+1.
- With `out0_ready` held at 1, one element is accepted per cycle. For N elements: EOS at t+1+N, `outCtrl_valid` at t+2+N.
- Completion handshake at cycle u gives `inCtrl_ready`=1 at u+1. There is no overlap between sequences.
- Backpressure with `out0_ready`=0 for any number of cycles causes no loss and no duplication.

## Structure
- Shared package `stream_source_pkg` holds:
  - the state enum (`IDLE`, `EMIT`, `EOS`, `DONE`);
  - the default `DATA_WIDTH`/`COUNT_WIDTH` localparams;
  - a packed element typedef {data, eos}.
- There is no sub-module. The block is one FSM plus a value register, a step register and a down-counter.

## Test plan
- Start with start=5, step=3, count=4, ready held at 1 → elements 5, 8, 11, 14 on consecutive cycles, then EOS (field0=0), then `outCtrl_valid` for one cycle.
- count=0 → EOS is the first element, one cycle after the start handshake, followed by the completion token.
- start=0xFFFF_FFFF_FFFF_FFFE, step=1, count=3 → elements 0x…FFFE, 0x…FFFF, 0.
- start=1, step=1, count=3, `out0_ready` toggling 0/1 every cycle → elements 1, 2, 3 and EOS exactly once each. Data is stable while valid&&!ready.
- Two back-to-back starts (7/1/2, then 100/10/1), with the second `inCtrl_valid` held high throughout → the second start is accepted only after the first completion. Output is 7, 8, EOS, done, then 100, EOS, done.
- Reset driven low during EMIT, after the 2nd of 5 elements → `out0_valid` drops immediately and `inCtrl_ready`=1. A fresh start then restarts cleanly from its own `cfg_start`.

Source files
------------

// File: rtl/stream_source_pkg.sv
// Shared types and defaults for the stream_source producer.
// Holds the FSM state encoding and the packed element layout used on the output stream.
package stream_source_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 64;
  localparam int DEFAULT_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    EOS  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] data;
    logic                          eos;
  } element_t;

endpackage

// File: rtl/stream_source.sv
// Stream producer: one start token yields an arithmetic sequence of cfg_count elements,
// then a single EOS element, then a completion token. All outputs are registered or state-decoded.
module stream_source
  import stream_source_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   inCtrl_valid,
  output logic                   inCtrl_ready,
  input  logic [DATA_WIDTH-1:0]  cfg_start,
  input  logic [DATA_WIDTH-1:0]  cfg_step,
  input  logic [COUNT_WIDTH-1:0] cfg_count,
  output logic                   out0_valid,
  input  logic                   out0_ready,
  output logic [DATA_WIDTH-1:0]  out0_data_field0,
  output logic                   out0_data_field1,
  output logic                   outCtrl_valid,
  input  logic                   outCtrl_ready
);

  state_t                 state;
  state_t                 next_state;
  logic [DATA_WIDTH-1:0]  value;
  logic [DATA_WIDTH-1:0]  step;
  logic [COUNT_WIDTH-1:0] remaining;
  logic                   start_fire;
  logic                   last_elem;

  assign start_fire = (state == IDLE) && inCtrl_valid;
  assign last_elem  = (remaining == COUNT_WIDTH'(1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state       = state;
    inCtrl_ready     = 1'b0;
    out0_valid       = 1'b0;
    out0_data_field1 = 1'b0;
    outCtrl_valid    = 1'b0;
    case (state)
      IDLE: begin
        inCtrl_ready = 1'b1;
        if (inCtrl_valid) begin
          next_state = (cfg_count == '0) ? EOS : EMIT;
        end
      end
      EMIT: begin
        out0_valid = 1'b1;
        if (out0_ready && last_elem) begin
          next_state = EOS;
        end
      end
      EOS: begin
        out0_valid       = 1'b1;
        out0_data_field1 = 1'b1;
        if (out0_ready) begin
          next_state = DONE;
        end
      end
      DONE: begin
        outCtrl_valid = 1'b1;
        if (outCtrl_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // The value register is cleared on entry to EOS so the EOS element carries payload 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value     <= '0;
      step      <= '0;
      remaining <= '0;
    end else if (start_fire) begin
      step      <= cfg_step;
      remaining <= cfg_count;
      value     <= (cfg_count == '0) ? '0 : cfg_start;
    end else if ((state == EMIT) && out0_ready) begin
      remaining <= remaining - COUNT_WIDTH'(1);
      value     <= last_elem ? '0 : value + step;
    end
  end

  assign out0_data_field0 = value;

endmodule

// File: tb/tb_stream_source.sv
// Self-checking bench for stream_source: table-driven sequences plus hand-written
// back-to-back and mid-sequence reset cases, with a scoreboard of expected elements.
module tb_stream_source;
  import stream_source_pkg::*;

  localparam int DW = 64;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          inCtrl_valid = 1'b0;
  logic          inCtrl_ready;
  logic [DW-1:0] cfg_start = '0;
  logic [DW-1:0] cfg_step = '0;
  logic [CW-1:0] cfg_count = '0;
  logic          out0_valid;
  logic          out0_ready = 1'b0;
  logic [DW-1:0] out0_data_field0;
  logic          out0_data_field1;
  logic          outCtrl_valid;
  logic          outCtrl_ready = 1'b1;

  stream_source #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clock            (clock),
    .reset            (reset),
    .inCtrl_valid     (inCtrl_valid),
    .inCtrl_ready     (inCtrl_ready),
    .cfg_start        (cfg_start),
    .cfg_step         (cfg_step),
    .cfg_count        (cfg_count),
    .out0_valid       (out0_valid),
    .out0_ready       (out0_ready),
    .out0_data_field0 (out0_data_field0),
    .out0_data_field1 (out0_data_field1),
    .outCtrl_valid    (outCtrl_valid),
    .outCtrl_ready    (outCtrl_ready)
  );

  always #5 clock = ~clock;

  int            checks = 0;
  int            failures = 0;
  element_t      exp_q[$];
  element_t      got_e;
  int            elem_seen = 0;
  int            done_seen = 0;
  logic [DW-1:0] last_data = '0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_eos = 1'b0;

  typedef struct {
    logic [DW-1:0] start;
    logic [DW-1:0] step;
    logic [CW-1:0] count;
    bit            toggle;
    logic [DW-1:0] exp_last;
    int            exp_cycles;
  } vec_t;

  vec_t vecs[5];

  task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%h required=0x%h", name, act, exp);
    end
  endtask

  // Scoreboard and hold-rule monitor, sampled mid-cycle.
  always @(negedge clock) begin
    if (reset) begin
      if (prev_stall) begin
        check_output("hold_valid", DW'(out0_valid), DW'(1));
        check_output("hold_data", out0_data_field0, prev_data);
        check_output("hold_eos", DW'(out0_data_field1), DW'(prev_eos));
      end
      if (out0_valid && out0_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_element actual=0x%h/%0b required=none", out0_data_field0, out0_data_field1);
        end else begin
          got_e = exp_q.pop_front();
          check_output("elem_data", out0_data_field0, got_e.data);
          check_output("elem_eos", DW'(out0_data_field1), DW'(got_e.eos));
        end
        elem_seen++;
        if (!out0_data_field1) last_data = out0_data_field0;
      end
      if (outCtrl_valid && outCtrl_ready) done_seen++;
      prev_stall = out0_valid && !out0_ready;
      prev_data  = out0_data_field0;
      prev_eos   = out0_data_field1;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic push_expected(input logic [DW-1:0] start, input logic [DW-1:0] step, input logic [CW-1:0] count);
    element_t e;
    for (int i = 0; i < int'(count); i++) begin
      e.data = start + step * DW'(i);
      e.eos  = 1'b0;
      exp_q.push_back(e);
    end
    e.data = '0;
    e.eos  = 1'b1;
    exp_q.push_back(e);
  endtask

  // Runs one full sequence; cycles counts edges from the start handshake to the completion handshake.
  task automatic apply_stimulus(input logic [DW-1:0] start, input logic [DW-1:0] step,
                                input logic [CW-1:0] count, input bit toggle, output int cycles);
    int d0;
    d0 = done_seen;
    check_output("idle_ready", DW'(inCtrl_ready), DW'(1));
    push_expected(start, step, count);
    inCtrl_valid = 1'b1;
    cfg_start    = start;
    cfg_step     = step;
    cfg_count    = count;
    out0_ready   = 1'b0;
    @(posedge clock);
    #1;
    inCtrl_valid = 1'b0;
    cycles = 0;
    while (done_seen == d0 && cycles < 200) begin
      cycles++;
      out0_ready = toggle ? (cycles % 2 == 0) : 1'b1;
      @(posedge clock);
      #1;
    end
    if (done_seen == d0) begin
      checks++;
      failures++;
      $display("[TB] FAIL seq_timeout actual=no_done required=done");
    end
  endtask

  initial begin
    int cyc;
    int d0;
    int e0;
    int k;

    vecs[0] = '{start: 64'd5, step: 64'd3, count: 16'd4, toggle: 1'b0, exp_last: 64'd14, exp_cycles: 6};
    vecs[1] = '{start: 64'h55, step: 64'd9, count: 16'd0, toggle: 1'b0, exp_last: 64'd0, exp_cycles: 2};
    vecs[2] = '{start: 64'hFFFF_FFFF_FFFF_FFFE, step: 64'd1, count: 16'd3, toggle: 1'b0, exp_last: 64'd0, exp_cycles: 5};
    vecs[3] = '{start: 64'd1, step: 64'd1, count: 16'd3, toggle: 1'b1, exp_last: 64'd3, exp_cycles: 9};
    vecs[4] = '{start: 64'h8000_0000_0000_0000, step: 64'h8000_0000_0000_0001, count: 16'd2, toggle: 1'b0,
                exp_last: 64'd1, exp_cycles: 4};

    #12;
    check_output("rst_in_ready", DW'(inCtrl_ready), DW'(1));
    check_output("rst_out_valid", DW'(out0_valid), DW'(0));
    check_output("rst_field0", out0_data_field0, DW'(0));
    check_output("rst_field1", DW'(out0_data_field1), DW'(0));
    check_output("rst_ctrl_valid", DW'(outCtrl_valid), DW'(0));
    @(posedge clock);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 5; i++) begin
      apply_stimulus(vecs[i].start, vecs[i].step, vecs[i].count, vecs[i].toggle, cyc);
      check_output($sformatf("vec%0d_cycles", i), DW'(cyc), DW'(vecs[i].exp_cycles));
      if (vecs[i].count != 0) check_output($sformatf("vec%0d_last", i), last_data, vecs[i].exp_last);
      check_output($sformatf("vec%0d_drained", i), DW'(exp_q.size()), DW'(0));
    end

    // Back-to-back: second start held valid with new config throughout the first sequence.
    d0 = done_seen;
    check_output("b2b_idle_ready", DW'(inCtrl_ready), DW'(1));
    push_expected(64'd7, 64'd1, 16'd2);
    push_expected(64'd100, 64'd10, 16'd1);
    inCtrl_valid = 1'b1;
    cfg_start = 64'd7; cfg_step = 64'd1; cfg_count = 16'd2;
    out0_ready = 1'b1;
    @(posedge clock);
    #1;
    cfg_start = 64'd100; cfg_step = 64'd10; cfg_count = 16'd1;
    k = 0;
    while (!inCtrl_ready && k < 50) begin
      @(posedge clock);
      #1;
      k++;
    end
    check_output("b2b_busy_cycles", DW'(k), DW'(4));
    check_output("b2b_first_done", DW'(done_seen - d0), DW'(1));
    @(posedge clock);
    #1;
    inCtrl_valid = 1'b0;
    k = 0;
    while (done_seen < d0 + 2 && k < 50) begin
      @(posedge clock);
      #1;
      k++;
    end
    check_output("b2b_total_done", DW'(done_seen - d0), DW'(2));
    check_output("b2b_drained", DW'(exp_q.size()), DW'(0));

    // Reset after the 2nd of 5 elements abandons the sequence.
    d0 = done_seen;
    e0 = elem_seen;
    push_expected(64'd10, 64'd5, 16'd5);
    inCtrl_valid = 1'b1;
    cfg_start = 64'd10; cfg_step = 64'd5; cfg_count = 16'd5;
    out0_ready = 1'b1;
    @(posedge clock);
    #1;
    inCtrl_valid = 1'b0;
    k = 0;
    while (elem_seen < e0 + 2 && k < 50) begin
      @(posedge clock);
      #1;
      k++;
    end
    check_output("rst_mid_elems", DW'(elem_seen - e0), DW'(2));
    check_output("rst_mid_valid_before", DW'(out0_valid), DW'(1));
    reset = 1'b0;
    #1;
    check_output("rst_mid_out_valid", DW'(out0_valid), DW'(0));
    check_output("rst_mid_in_ready", DW'(inCtrl_ready), DW'(1));
    check_output("rst_mid_ctrl_valid", DW'(outCtrl_valid), DW'(0));
    check_output("rst_mid_field0", out0_data_field0, DW'(0));
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b1;
    apply_stimulus(64'd20, 64'd2, 16'd2, 1'b0, cyc);
    check_output("after_rst_cycles", DW'(cyc), DW'(4));
    check_output("after_rst_last", last_data, DW'(22));
    check_output("after_rst_done", DW'(done_seen - d0), DW'(1));
    check_output("after_rst_drained", DW'(exp_q.size()), DW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
